fifo_protocol_checker: RTL

- Synthesizable, parametrised in-circuit checker for a synchronous FIFO: shadow-models occupancy, storage and status outputs, then compares every DUT output each sampled cycle.
- Keeps saturating error/correct counters, a sticky per-check error vector and first-failure capture.
- Successor to the testbench monitor/scoreboard. Adds generic width, depth and thresholds, a per-check enable mask, and silicon/FPGA deployability.

---
 rtl/fifo_protocol_checker.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_protocol_checker.sv
// In-circuit protocol checker for a synchronous FIFO. It shadow-models occupancy, storage and status,
// compares the observed DUT outputs on every sampled edge, and keeps error statistics.
module fifo_protocol_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_en,
  input  logic                          clear,
  input  logic [7:0]                    check_mask,
  input  logic                          dut_rst_n,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic [DATA_WIDTH-1:0]         data_out,
  input  logic                          full,
  input  logic                          empty,
  input  logic                          almostfull,
  input  logic                          almostempty,
  input  logic                          wr_ack,
  input  logic                          overflow,
  input  logic                          underflow,
  output logic [7:0]                    err_vec,
  output logic [CNT_WIDTH-1:0]          error_count,
  output logic [CNT_WIDTH-1:0]          correct_count,
  output logic [7:0]                    first_err_vec,
  output logic [CNT_WIDTH-1:0]          first_err_cycle,
  output logic [$clog2(FIFO_DEPTH):0]   model_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]        DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]        AF_C    = CW'(FIFO_DEPTH - AF_MARGIN);
  localparam logic [CW-1:0]        AE_C    = CW'(AE_MARGIN);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic                  expWrAck_q, expWrAck_d;
  logic                  expOverflow_q, expOverflow_d;
  logic                  expUnderflow_q, expUnderflow_d;
  logic                  expRdValid_q, expRdValid_d;
  logic [DATA_WIDTH-1:0] expData_q, expData_d;
  logic [7:0]            errVec_q, errVec_d;
  logic [CNT_WIDTH-1:0]  errorCount_q, errorCount_d;
  logic [CNT_WIDTH-1:0]  correctCount_q, correctCount_d;
  logic [7:0]            firstErrVec_q, firstErrVec_d;
  logic [CNT_WIDTH-1:0]  firstErrCycle_q, firstErrCycle_d;
  logic [CNT_WIDTH-1:0]  cycleCount_q, cycleCount_d;
  logic                  hasFailed_q, hasFailed_d;

  logic [7:0] rawMis;
  logic [7:0] mismatch;
  logic       wrOk, rdOk, doCompare;

  always_comb begin
    rawMis[0] = full        != (count_q == DEPTH_C);
    rawMis[1] = empty       != (count_q == '0);
    rawMis[2] = almostfull  != (count_q == AF_C);
    rawMis[3] = almostempty != (count_q == AE_C);
    rawMis[4] = wr_ack      != expWrAck_q;
    rawMis[5] = overflow    != expOverflow_q;
    rawMis[6] = underflow   != expUnderflow_q;
    rawMis[7] = expRdValid_q & (data_out != expData_q);
    mismatch  = rawMis & check_mask;
    doCompare = sample_en & dut_rst_n & ~clear;
    // Accept decisions use the pre-update count, so wr&rd at empty only writes and at full only reads.
    wrOk      = wr_en & (count_q != DEPTH_C);
    rdOk      = rd_en & (count_q != '0);
  end

  always_comb begin
    count_d         = count_q;
    wrPtr_d         = wrPtr_q;
    rdPtr_d         = rdPtr_q;
    expWrAck_d      = expWrAck_q;
    expOverflow_d   = expOverflow_q;
    expUnderflow_d  = expUnderflow_q;
    expRdValid_d    = expRdValid_q;
    expData_d       = expData_q;
    errVec_d        = errVec_q;
    errorCount_d    = errorCount_q;
    correctCount_d  = correctCount_q;
    firstErrVec_d   = firstErrVec_q;
    firstErrCycle_d = firstErrCycle_q;
    cycleCount_d    = cycleCount_q;
    hasFailed_d     = hasFailed_q;

    if (sample_en) begin
      if (!dut_rst_n) begin
        count_d        = '0;
        wrPtr_d        = '0;
        rdPtr_d        = '0;
        expWrAck_d     = 1'b0;
        expOverflow_d  = 1'b0;
        expUnderflow_d = 1'b0;
        expRdValid_d   = 1'b0;
      end else begin
        expWrAck_d     = wrOk;
        expOverflow_d  = wr_en & ~wrOk;
        expUnderflow_d = rd_en & ~rdOk;
        expRdValid_d   = rdOk;
        if (wrOk) begin
          wrPtr_d = wrPtr_q + PW'(1);
        end
        if (rdOk) begin
          expData_d = mem_q[rdPtr_q];
          rdPtr_d   = rdPtr_q + PW'(1);
        end
        count_d = count_q + CW'(wrOk) - CW'(rdOk);
      end
    end

    // Clear wipes statistics only; the shadow model keeps tracking the DUT.
    if (clear) begin
      errVec_d        = '0;
      errorCount_d    = '0;
      correctCount_d  = '0;
      firstErrVec_d   = '0;
      firstErrCycle_d = '0;
      cycleCount_d    = '0;
      hasFailed_d     = 1'b0;
    end else if (sample_en) begin
      cycleCount_d = cycleCount_q + CNT_ONE;
      if (doCompare) begin
        if (|mismatch) begin
          errVec_d = errVec_q | mismatch;
          if (errorCount_q != '1) begin
            errorCount_d = errorCount_q + CNT_ONE;
          end
          if (!hasFailed_q) begin
            firstErrVec_d   = mismatch;
            firstErrCycle_d = cycleCount_q;
            hasFailed_d     = 1'b1;
          end
        end else if (correctCount_q != '1) begin
          correctCount_d = correctCount_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sample_en && dut_rst_n && wrOk) begin
      mem_q[wrPtr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q         <= '0;
      wrPtr_q         <= '0;
      rdPtr_q         <= '0;
      expWrAck_q      <= 1'b0;
      expOverflow_q   <= 1'b0;
      expUnderflow_q  <= 1'b0;
      expRdValid_q    <= 1'b0;
      expData_q       <= '0;
      errVec_q        <= '0;
      errorCount_q    <= '0;
      correctCount_q  <= '0;
      firstErrVec_q   <= '0;
      firstErrCycle_q <= '0;
      cycleCount_q    <= '0;
      hasFailed_q     <= 1'b0;
    end else begin
      count_q         <= count_d;
      wrPtr_q         <= wrPtr_d;
      rdPtr_q         <= rdPtr_d;
      expWrAck_q      <= expWrAck_d;
      expOverflow_q   <= expOverflow_d;
      expUnderflow_q  <= expUnderflow_d;
      expRdValid_q    <= expRdValid_d;
      expData_q       <= expData_d;
      errVec_q        <= errVec_d;
      errorCount_q    <= errorCount_d;
      correctCount_q  <= correctCount_d;
      firstErrVec_q   <= firstErrVec_d;
      firstErrCycle_q <= firstErrCycle_d;
      cycleCount_q    <= cycleCount_d;
      hasFailed_q     <= hasFailed_d;
    end
  end

  assign err_vec         = errVec_q;
  assign error_count     = errorCount_q;
  assign correct_count   = correctCount_q;
  assign first_err_vec   = firstErrVec_q;
  assign first_err_cycle = firstErrCycle_q;
  assign model_count     = count_q;

endmodule
